// File: rtl/iob_fifo_burst_arb.sv
// iob_fifo_burst_arb
// Round-robin burst arbiter for the write port of one FIFO. A requester is
// granted only when the FIFO can absorb a whole burst. It then owns the port
// until exactly BURST_LEN words have been written, so bursts never interleave.
// Lives entirely in the FIFO write clock domain.

module iob_fifo_burst_arb #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   input  logic                      rst_i,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ-1:0]          valid_i,
   input  logic [N_REQ*DATA_W-1:0]   data_i,
   output logic [N_REQ-1:0]          ack_o,
   output logic [N_REQ-1:0]          grant_o,
   output logic                      busy_o,
   input  logic [ADDR_W:0]           w_level_i,
   input  logic                      w_full_i,
   output logic                      w_en_o,
   output logic [DATA_W-1:0]         w_data_o
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   // Capacity and burst size at the width of the free-space arithmetic.
   localparam logic [ADDR_W+1:0] CAPACITY    = {2'b01, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W+1:0] BURST_WORDS = (ADDR_W+2)'(BURST_LEN);
   localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(BURST_LEN - 1);
   localparam logic [PTR_W-1:0]  LAST_REQ    = PTR_W'(N_REQ - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t             state;
   logic [N_REQ-1:0]   grant;
   logic [PTR_W-1:0]   ptr;
   logic [CNT_W-1:0]   cnt;

   logic [ADDR_W+1:0]  free_words;
   logic               space_ok;
   logic               pick_valid;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   scan_idx;
   logic [PTR_W-1:0]   owner_idx;
   logic [PTR_W-1:0]   ptr_after;

   // Room for a whole burst: level already reflects our own last write.
   assign free_words = CAPACITY - {1'b0, w_level_i};
   assign space_ok   = (free_words >= BURST_WORDS);

   // Round-robin pick: first requester at or after ptr, wrapping mod N_REQ.
   // Scanning from the far end lets the nearest hit overwrite the others.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         scan_idx = PTR_W'((int'(ptr) + i) % N_REQ);
         if (req_i[scan_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Index of the current owner, used to advance the pointer past it.
   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) owner_idx = PTR_W'(i);
      end
   end

   assign ptr_after = (owner_idx == LAST_REQ) ? '0 : owner_idx + 1'b1;

   // Write path is purely combinational; grant is all-zero outside BURST,
   // which forces w_en_o, ack_o and w_data_o to zero there.
   assign w_en_o = (state == BURST) & (|(grant & valid_i)) & ~w_full_i;
   assign ack_o  = grant & {N_REQ{w_en_o}};

   // Forward the owner's word; one-hot grant makes this a simple mux.
   always_comb begin
      w_data_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) w_data_o = data_i[i*DATA_W +: DATA_W];
      end
   end

   // Arbitration FSM: grant in IDLE, count words in BURST, rotate on completion.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else if (rst_i) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid && space_ok) begin
                  grant    <= '0;
                  grant[pick_idx] <= 1'b1;
                  cnt      <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (w_en_o) begin
                  if (cnt == LAST_WORD) begin
                     state <= IDLE;
                     grant <= '0;
                     ptr   <= ptr_after;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

   assign grant_o = grant;
   assign busy_o  = (state == BURST);

endmodule

// File: tb/tb_iob_fifo_burst_arb.sv
// Directed bench for iob_fifo_burst_arb (N_REQ=4, DATA_W=32, ADDR_W=4,
// BURST_LEN=4). Inputs change 1 ns after the rising edge; outputs are
// checked a further 1 ns later, well clear of the next edge.

module tb_iob_fifo_burst_arb;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 4;
   localparam int BURST_LEN = 4;

   logic                    clk_i = 1'b0;
   logic                    arst_n_i;
   logic                    rst_i;
   logic [N_REQ-1:0]        req_i;
   logic [N_REQ-1:0]        valid_i;
   logic [N_REQ*DATA_W-1:0] data_i;
   logic [N_REQ-1:0]        ack_o;
   logic [N_REQ-1:0]        grant_o;
   logic                    busy_o;
   logic [ADDR_W:0]         w_level_i;
   logic                    w_full_i;
   logic                    w_en_o;
   logic [DATA_W-1:0]       w_data_o;

   int vectors     = 0;
   int miscompares = 0;

   iob_fifo_burst_arb #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)
   ) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(rst_i),
      .req_i(req_i), .valid_i(valid_i), .data_i(data_i),
      .ack_o(ack_o), .grant_o(grant_o), .busy_o(busy_o),
      .w_level_i(w_level_i), .w_full_i(w_full_i),
      .w_en_o(w_en_o), .w_data_o(w_data_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [DATA_W-1:0] word_of(int k);
      return 32'hD0D0_0000 + 32'(k) * 32'h0000_0101;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Checks a full unstalled burst by requester g, starting just after the
   // grant edge; ends just after the edge that returns the arbiter to IDLE.
   task automatic burst4(input int g);
      check("burst_grant", grant_o, 64'(1 << g));
      check("burst_busy", busy_o, 1);
      for (int w = 0; w < BURST_LEN; w++) begin
         check("burst_wen", w_en_o, 1);
         check("burst_ack", ack_o, 64'(1 << g));
         check("burst_data", w_data_o, word_of(g));
         tick();
      end
      check("burst_end_busy", busy_o, 0);
      check("burst_end_grant", grant_o, 0);
      check("burst_end_wen", w_en_o, 0);
   endtask

   initial begin
      int writes;
      logic [5:0] stall_pat;

      for (int k = 0; k < N_REQ; k++) data_i[k*DATA_W +: DATA_W] = word_of(k);
      arst_n_i  = 1'b0;
      rst_i     = 1'b0;
      req_i     = 4'hF;
      valid_i   = 4'hF;
      w_level_i = '0;
      w_full_i  = 1'b0;

      // Reset holds everything quiet even with all requests up.
      tick(); tick(); tick();
      check("rst_grant", grant_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_wen", w_en_o, 0);
      check("rst_ack", ack_o, 0);
      check("rst_wdata", w_data_o, 0);
      arst_n_i = 1'b1;
      tick();
      check("first_grant", grant_o, 4'b0001);

      // Round robin 0,1,2,3,0 with one idle cycle between bursts.
      burst4(0); tick();
      burst4(1); tick();
      burst4(2); tick();
      burst4(3); tick();
      burst4(0);

      // Space gate: free=3 blocks, free=4 grants. ptr is now 1.
      req_i     = 4'b0001;
      w_level_i = 5'd13;
      tick();
      check("gate13_grant", grant_o, 0);
      check("gate13_busy", busy_o, 0);
      tick();
      check("gate13_grant2", grant_o, 0);
      w_level_i = 5'd12;
      tick();
      check("gate12_grant", grant_o, 4'b0001);
      burst4(0);

      // Stall: requester 1, valid pattern 1,0,0,1,1,1; requester 0 keeps
      // valid data up and must never reach the FIFO.
      w_level_i = '0;
      req_i     = 4'b0010;
      tick();
      check("stall_grant", grant_o, 4'b0010);
      req_i     = 4'b0000;
      stall_pat = 6'b111001;
      writes    = 0;
      for (int c = 0; c < 6; c++) begin
         valid_i = {2'b00, stall_pat[c], 1'b1};
         #1;
         check("stall_busy", busy_o, 1);
         check("stall_wen", w_en_o, stall_pat[c]);
         check("stall_ack", ack_o, stall_pat[c] ? 4'b0010 : 4'b0000);
         check("stall_data", w_data_o, word_of(1));
         if (w_en_o) writes++;
         tick();
      end
      check("stall_writes", writes, 4);
      check("stall_end_busy", busy_o, 0);
      valid_i = 4'hF;

      // Dropping req mid-burst does not end it. ptr is now 2.
      req_i = 4'b0100;
      tick();
      check("drop_grant", grant_o, 4'b0100);
      writes = 0;
      for (int w = 0; w < BURST_LEN; w++) begin
         if (w == 1) req_i = 4'b0000;
         #1;
         check("drop_busy", busy_o, 1);
         if (w_en_o) writes++;
         tick();
      end
      check("drop_writes", writes, 4);
      check("drop_end_busy", busy_o, 0);

      // Full safety net: cnt holds while w_full_i is high. ptr is now 3.
      req_i = 4'b1000;
      tick();
      check("full_grant", grant_o, 4'b1000);
      req_i = 4'b0000;
      check("full_w0", w_en_o, 1);
      tick();
      w_full_i = 1'b1;
      #1;
      check("full_wen", w_en_o, 0);
      check("full_ack", ack_o, 0);
      tick(); tick();
      check("full_busy", busy_o, 1);
      w_full_i = 1'b0;
      #1;
      check("full_resume", w_en_o, 1);
      tick(); tick();
      check("full_busy_last", busy_o, 1);
      check("full_ack_last", ack_o, 4'b1000);
      tick();
      check("full_end_busy", busy_o, 0);

      // Async reset mid-burst: advance ptr to 1, cut requester 1 after word 2.
      req_i = 4'b0001;
      tick();
      burst4(0);
      req_i = 4'b0010;
      tick();
      check("abort_grant", grant_o, 4'b0010);
      req_i = 4'hF;
      tick(); tick();
      check("abort_busy_pre", busy_o, 1);
      arst_n_i = 1'b0;
      #1;
      check("abort_grant0", grant_o, 0);
      check("abort_busy0", busy_o, 0);
      check("abort_wen0", w_en_o, 0);
      check("abort_ack0", ack_o, 0);
      #2;
      arst_n_i = 1'b1;
      tick();
      check("abort_regrant", grant_o, 4'b0001);

      // Soft reset behaves the same at the next edge.
      tick();
      rst_i = 1'b1;
      tick();
      check("srst_grant", grant_o, 0);
      check("srst_busy", busy_o, 0);
      rst_i = 1'b0;
      tick();
      check("srst_regrant", grant_o, 4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
